// File: rtl/nmea_pkg.sv
// Shared ASCII constants, parser state encoding and character helpers
// for the NMEA GGA parser.
package nmea_pkg;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_N      = 8'h4E;
  localparam logic [7:0] CH_S      = 8'h53;
  localparam logic [7:0] CH_E      = 8'h45;
  localparam logic [7:0] CH_W      = 8'h57;
  localparam logic [7:0] CH_G      = 8'h47;
  localparam logic [7:0] CH_A      = 8'h41;

  typedef enum logic [2:0] {HUNT, ADDR, FIELD, CK_HI, CK_LO} state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Only uppercase hex is legal in the checksum
  function automatic logic is_hex(input logic [7:0] c);
    return is_digit(c) || ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
    return is_digit(c) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/nmea_dec_acc.sv
// Decimal digit accumulator: value = value*10 + digit, with a digit count
// so the caller can cap how many digits are taken.
module nmea_dec_acc #(
  parameter int unsigned W     = 32,
  parameter int unsigned MAX_D = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic [3:0]                   digit,
  output logic [W-1:0]                 value,
  output logic [$clog2(MAX_D+1)-1:0]   count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
    end else if (en) begin
      value <= value * W'(10) + W'(digit);
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/nmea_gga_parser.sv
// NMEA-0183 GGA sentence parser: checksum validation, field extraction and
// atomic commit of position/fix outputs on a clean sentence with a fix.
module nmea_gga_parser
  import nmea_pkg::*;
#(
  parameter int unsigned COORD_W    = 32,
  parameter int unsigned MAX_DIGITS = 9,
  parameter int unsigned MAX_LEN    = 82
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [COORD_W-1:0] latitude,
  output logic [COORD_W-1:0] longitude,
  output logic               lat_south,
  output logic               lon_west,
  output logic [3:0]         fix_quality,
  output logic [7:0]         num_sats,
  output logic               data_valid,
  output logic               cksum_err,
  output logic               fmt_err
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned DW = $clog2(MAX_DIGITS + 1);

  state_t state, state_nxt;

  logic [7:0]         cksum;
  logic [LW-1:0]      len;
  logic [3:0]         field;
  logic [2:0]         addr_idx;
  logic [3:0]         ck_hi;
  logic               lat_s, lat_seen, lon_w, lon_seen, fix_seen;
  logic [3:0]         fix;
  logic [7:0]         sats;
  logic [1:0]         sats_cnt;
  logic [COORD_W-1:0] lat_val, lon_val;
  logic [DW-1:0]      lat_cnt, lon_cnt;
  logic [3:0]         dig;

  logic is_dollar, overflow, addr_mismatch, coord_bad, hex_ok, ck_match;
  logic start, lat_en, lon_en, commit_nxt, ck_err_nxt, fmt_nxt;

  assign dig       = rx_data[3:0];
  assign is_dollar = (rx_data == CH_DOLLAR);
  assign overflow  = (state != HUNT) && (len >= LW'(MAX_LEN));
  assign hex_ok    = is_hex(rx_data);
  assign ck_match  = ({ck_hi, hex_to_nibble(rx_data)} == cksum);
  assign coord_bad = (state == FIELD) && ((field == 4'd2) || (field == 4'd4)) &&
                     !is_digit(rx_data) && (rx_data != CH_DOT) &&
                     (rx_data != CH_COMMA) && (rx_data != CH_STAR);

  always_comb begin
    addr_mismatch = 1'b0;
    case (addr_idx)
      3'd2, 3'd3: addr_mismatch = (rx_data != CH_G);
      3'd4:       addr_mismatch = (rx_data != CH_A);
      default:    addr_mismatch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rx_valid) begin
      if (is_dollar) state_nxt = ADDR;
      else if (overflow) state_nxt = HUNT;
      else begin
        case (state)
          ADDR: begin
            if (addr_mismatch) state_nxt = HUNT;
            else if (addr_idx == 3'd5) state_nxt = (rx_data == CH_COMMA) ? FIELD : HUNT;
          end
          FIELD: begin
            if (coord_bad) state_nxt = HUNT;
            else if (rx_data == CH_STAR) state_nxt = CK_HI;
          end
          CK_HI:   state_nxt = hex_ok ? CK_LO : HUNT;
          CK_LO:   state_nxt = HUNT;
          default: state_nxt = state;
        endcase
      end
    end
  end

  always_comb begin
    start      = 1'b0;
    fmt_nxt    = 1'b0;
    ck_err_nxt = 1'b0;
    commit_nxt = 1'b0;
    lat_en     = 1'b0;
    lon_en     = 1'b0;
    if (rx_valid) begin
      if (is_dollar) start = 1'b1;
      else if (overflow) fmt_nxt = 1'b1;
      else begin
        case (state)
          ADDR:  fmt_nxt = (addr_idx == 3'd5) && (rx_data != CH_COMMA);
          FIELD: begin
            fmt_nxt = coord_bad;
            lat_en  = (field == 4'd2) && is_digit(rx_data) && (lat_cnt < DW'(MAX_DIGITS));
            lon_en  = (field == 4'd4) && is_digit(rx_data) && (lon_cnt < DW'(MAX_DIGITS));
          end
          CK_HI: fmt_nxt = !hex_ok;
          CK_LO: begin
            if (!hex_ok)       fmt_nxt    = 1'b1;
            else if (ck_match) commit_nxt = lat_seen && lon_seen && (fix != 4'd0);
            else               ck_err_nxt = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  nmea_dec_acc #(.W(COORD_W), .MAX_D(MAX_DIGITS)) u_lat (
    .clk(clk), .rst(rst), .clr(start), .en(lat_en), .digit(dig),
    .value(lat_val), .count(lat_cnt)
  );

  nmea_dec_acc #(.W(COORD_W), .MAX_D(MAX_DIGITS)) u_lon (
    .clk(clk), .rst(rst), .clr(start), .en(lon_en), .digit(dig),
    .value(lon_val), .count(lon_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum <= '0; len <= '0; field <= '0; addr_idx <= '0; ck_hi <= '0;
      lat_s <= 1'b0; lat_seen <= 1'b0; lon_w <= 1'b0; lon_seen <= 1'b0;
      fix <= '0; fix_seen <= 1'b0; sats <= '0; sats_cnt <= '0;
      latitude <= '0; longitude <= '0; lat_south <= 1'b0; lon_west <= 1'b0;
      fix_quality <= '0; num_sats <= '0;
      data_valid <= 1'b0; cksum_err <= 1'b0; fmt_err <= 1'b0;
    end else begin
      data_valid <= commit_nxt;
      cksum_err  <= ck_err_nxt;
      fmt_err    <= fmt_nxt;
      if (start) begin
        cksum <= '0; len <= LW'(1); field <= '0; addr_idx <= '0;
        lat_seen <= 1'b0; lon_seen <= 1'b0; fix <= '0; fix_seen <= 1'b0;
        sats <= '0; sats_cnt <= '0;
      end else if (rx_valid && (state != HUNT) && !overflow) begin
        len <= len + 1'b1;
        case (state)
          ADDR: begin
            cksum    <= cksum ^ rx_data;
            addr_idx <= addr_idx + 1'b1;
            if (addr_idx == 3'd5) field <= 4'd1;
          end
          FIELD: begin
            if (rx_data != CH_STAR) cksum <= cksum ^ rx_data;
            if (rx_data == CH_COMMA) begin
              if (field != 4'hF) field <= field + 1'b1;
            end else begin
              case (field)
                4'd3: if (rx_data == CH_N || rx_data == CH_S) begin
                  lat_s <= (rx_data == CH_S); lat_seen <= 1'b1;
                end
                4'd5: if (rx_data == CH_E || rx_data == CH_W) begin
                  lon_w <= (rx_data == CH_W); lon_seen <= 1'b1;
                end
                4'd6: if (is_digit(rx_data) && !fix_seen) begin
                  fix <= dig; fix_seen <= 1'b1;
                end
                4'd7: if (is_digit(rx_data) && (sats_cnt != 2'd2)) begin
                  sats <= sats * 8'd10 + {4'd0, dig}; sats_cnt <= sats_cnt + 1'b1;
                end
                default: ;
              endcase
            end
          end
          CK_HI:   ck_hi <= hex_to_nibble(rx_data);
          default: ;
        endcase
      end
      if (commit_nxt) begin
        latitude <= lat_val; longitude <= lon_val;
        lat_south <= lat_s; lon_west <= lon_w;
        fix_quality <= fix; num_sats <= sats;
      end
    end
  end

endmodule

// File: tb/tb_nmea_gga_parser.sv
// Directed bench for nmea_gga_parser: a table of whole sentences with
// expected pulse counts and outputs, plus hand sequences for length/reset/gaps.
module tb_nmea_gga_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] latitude, longitude;
  logic        lat_south, lon_west;
  logic [3:0]  fix_quality;
  logic [7:0]  num_sats;
  logic        data_valid, cksum_err, fmt_err;

  nmea_gga_parser #(.COORD_W(32), .MAX_DIGITS(9), .MAX_LEN(82)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .latitude(latitude), .longitude(longitude), .lat_south(lat_south),
    .lon_west(lon_west), .fix_quality(fix_quality), .num_sats(num_sats),
    .data_valid(data_valid), .cksum_err(cksum_err), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int dv_cnt = 0, ck_cnt = 0, fe_cnt = 0, overlap_cnt = 0;

  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (cksum_err)  ck_cnt++;
    if (fmt_err)    fe_cnt++;
    if ((32'(data_valid) + 32'(cksum_err) + 32'(fmt_err)) > 1) overlap_cnt++;
  end

  typedef struct {
    string       name;
    string       line;
    int          dv, ck, fe;
    logic [31:0] lat, lon;
    logic        s, w;
    logic [3:0]  fix;
    logic [7:0]  sats;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic string with_ck(input string body);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < body.len(); i++) x = x ^ body[i];
    return {"$", body, "*", $sformatf("%02X", x)};
  endfunction

  function automatic vec_t mk(input string name, input string line, input int dv, input int ck,
                              input int fe, input logic [31:0] lat, input logic [31:0] lon,
                              input logic s, input logic w, input logic [3:0] fix,
                              input logic [7:0] sats);
    vec_t v;
    v.name = name; v.line = line; v.dv = dv; v.ck = ck; v.fe = fe;
    v.lat = lat; v.lon = lon; v.s = s; v.w = w; v.fix = fix; v.sats = sats;
    return v;
  endfunction

  // Junk '$' is placed on rx_data during gaps to prove invalid cycles are ignored
  task automatic send_line(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_data  = s[i];
      rx_valid = 1'b1;
      if (gaps) begin
        int g = $urandom_range(0, 4);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          rx_valid = 1'b0;
          rx_data  = 8'h24;
        end
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    dv_cnt = 0; ck_cnt = 0; fe_cnt = 0;
  endtask

  task automatic chk_outs(input string n, input logic [31:0] lat, input logic [31:0] lon,
                          input logic s, input logic w, input logic [3:0] fix, input logic [7:0] sats);
    chk({n, " latitude"},    latitude,    lat);
    chk({n, " longitude"},   longitude,   lon);
    chk({n, " lat_south"},   lat_south,   s);
    chk({n, " lon_west"},    lon_west,    w);
    chk({n, " fix_quality"}, fix_quality, fix);
    chk({n, " num_sats"},    num_sats,    sats);
  endtask

  task automatic chk_pulses(input string n, input int dv, input int ck, input int fe);
    chk({n, " data_valid pulses"}, dv_cnt, dv);
    chk({n, " cksum_err pulses"},  ck_cnt, ck);
    chk({n, " fmt_err pulses"},    fe_cnt, fe);
  endtask

  localparam string S1 = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47";

  initial begin
    string long_line;
    string b3;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    b3 = "GNGGA,000001,3351.5000,S,15112.2500,W,2,12,1.0,10.0,M,0.0,M,,";
    vecs.push_back(mk("gga_basic", S1, 1, 0, 0, 32'd4807038, 32'd1131000, 0, 0, 4'd1, 8'd8));
    vecs.push_back(mk("bad_cksum", "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48",
                      0, 1, 0, 32'd4807038, 32'd1131000, 0, 0, 4'd1, 8'd8));
    vecs.push_back(mk("gn_sw", with_ck(b3), 1, 0, 0, 32'd33515000, 32'd151122500, 1, 1, 4'd2, 8'd12));
    vecs.push_back(mk("rmc", with_ck("GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W"),
                      0, 0, 0, 32'd33515000, 32'd151122500, 1, 1, 4'd2, 8'd12));
    vecs.push_back(mk("fix0", with_ck("GPGGA,123519,4807.038,N,01131.000,E,0,08,0.9,545.4,M,46.9,M,,"),
                      0, 0, 0, 32'd33515000, 32'd151122500, 1, 1, 4'd2, 8'd12));
    vecs.push_back(mk("lower_hex", "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*4a",
                      0, 0, 1, 32'd33515000, 32'd151122500, 1, 1, 4'd2, 8'd12));
    vecs.push_back(mk("bad_lat_char", with_ck("GPGGA,1,48X7,N,01131.000,E,1,08,,,,,,"),
                      0, 0, 1, 32'd33515000, 32'd151122500, 1, 1, 4'd2, 8'd12));
    vecs.push_back(mk("no_comma", "$GPGGAX,1,2*00",
                      0, 0, 1, 32'd33515000, 32'd151122500, 1, 1, 4'd2, 8'd12));
    vecs.push_back(mk("max_digits", with_ck("GPGGA,1,1234.567891,N,98765.4321012,E,6,123,,,,,,,"),
                      1, 0, 0, 32'd123456789, 32'd987654321, 0, 0, 4'd6, 8'd12));
    vecs.push_back(mk("dollar_restart", {"$GPGGA,123519,48", S1},
                      1, 0, 0, 32'd4807038, 32'd1131000, 0, 0, 4'd1, 8'd8));

    repeat (3) @(negedge clk);
    #1;
    chk_outs("reset", 32'd0, 32'd0, 0, 0, 4'd0, 8'd0);
    chk_pulses("reset", 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      clear_counts();
      send_line(vecs[i].line, 1'b0);
      chk_pulses(vecs[i].name, vecs[i].dv, vecs[i].ck, vecs[i].fe);
      chk_outs(vecs[i].name, vecs[i].lat, vecs[i].lon, vecs[i].s, vecs[i].w,
               vecs[i].fix, vecs[i].sats);
    end

    // 82 characters are legal; the 83rd must raise fmt_err exactly once
    long_line = "$GPGGA,";
    for (int i = 0; i < 75; i++) long_line = {long_line, "1"};
    clear_counts();
    send_line(long_line, 1'b0);
    chk_pulses("len82", 0, 0, 0);
    send_line("1", 1'b0);
    chk_pulses("len83", 0, 0, 1);
    send_line("1111111", 1'b0);
    chk_pulses("len90", 0, 0, 1);
    chk_outs("len90", 32'd4807038, 32'd1131000, 0, 0, 4'd1, 8'd8);

    // Reset mid-sentence, then sentence 1 with random rx_valid gaps
    clear_counts();
    send_line("$GNGGA,000001,3351", 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_outs("mid_reset", 32'd0, 32'd0, 0, 0, 4'd0, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    clear_counts();
    send_line(S1, 1'b1);
    chk_pulses("gapped", 1, 0, 0);
    chk_outs("gapped", 32'd4807038, 32'd1131000, 0, 0, 4'd1, 8'd8);

    chk("pulse_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmea_gga_parser.md
# nmea_gga_parser

Parametrised NMEA-0183 GGA sentence parser that sits between the GPS UART receiver and the location/alert logic. It accepts any talker ID, validates the XOR checksum, and extracts latitude, longitude, hemispheres, fix quality and satellite count. Position outputs update only on a checksum-clean sentence with a valid fix, so downstream logic never sees a partial or corrupted position. Malformed and corrupted sentences produce error pulses for diagnostics.

## Interface
- COORD_W, 32: width of the latitude/longitude accumulators.
- MAX_DIGITS, 9: digits accumulated per coordinate; further digits are ignored. Require 10^MAX_DIGITS ≤ 2^COORD_W.
- MAX_LEN, 82: maximum characters from '$' to the second checksum character, inclusive.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data is valid this cycle. There is no backpressure; every valid byte is consumed.
- latitude  out  COORD_W  ddmm.mmmm digits with the decimal point removed, unsigned.
- longitude  out  COORD_W  dddmm.mmmm digits with the decimal point removed, unsigned.
- lat_south  out  1  1 = 'S'.
- lon_west  out  1  1 = 'W'.
- fix_quality  out  4  GGA field 6, single digit.
- num_sats  out  8  GGA field 7, binary value of up to 2 digits.
- data_valid  out  1  one-cycle pulse; the outputs above were just updated.
- cksum_err  out  1  one-cycle pulse on checksum mismatch.
- fmt_err  out  1  one-cycle pulse on malformed sentence.

## Operation
- States:
  - HUNT: wait for '$'.
  - ADDR: 5 address characters.
  - FIELD: comma-separated fields.
  - CK_HI / CK_LO: checksum hex digits.
- HUNT:
  - On '$', clear the checksum, length counter, field index, accumulators and seen-flags.
  - Go to ADDR.
- ADDR:
  - Characters 1–2 (talker ID) may be any value.
  - Characters 3–5 must be "GGA". Otherwise go to HUNT silently, because other sentence types are expected traffic.
  - After the 5th character, expect ','. Anything else raises fmt_err and returns to HUNT.
- Field index increments on every ',' in FIELD state:
  - 1 (time): skipped.
  - 2 (lat): acc = acc*10 + digit, up to MAX_DIGITS. '.' is ignored. Any other character raises fmt_err.
  - 3: 'N'/'S' sets the latitude direction and its seen-flag.
  - 4 (lon): same rules as field 2.
  - 5: 'E'/'W' sets the longitude direction and its seen-flag.
  - 6: the first digit becomes the fix value.
  - 7: num_sats = num_sats*10 + digit, for at most 2 digits.
  - 8 and above: skipped.
- Checksum:
  - XOR every character after '$' up to, but not including, '*'.
  - '*' in FIELD state moves to CK_HI.
  - CK_HI and CK_LO accept 0-9 and A-F. Lowercase and any other character raise fmt_err and return to HUNT.
- Commit on CK_LO, when the received byte equals the computed XOR:
  - If both seen-flags are set and fix ≠ 0, load all outputs and pulse data_valid.
  - Otherwise, produce no pulse and leave the outputs unchanged. This is not an error.
- On checksum mismatch: pulse cksum_err. Outputs are unchanged.
- A '$' in any state other than HUNT restarts parsing from ADDR without an error. The partial sentence is discarded.
- The length counter exceeding MAX_LEN raises fmt_err and returns to HUNT.
- All outputs hold their values between commits.

## Timing
- Reset values: every output is 0, and the state is HUNT.
- Reset asserted mid-sentence aborts it; the first '$' after reset release starts a fresh parse.
- Each byte is processed in the cycle rx_valid is high. Bytes may arrive back-to-back, one per clock.
- data_valid, cksum_err and fmt_err are registered. Each rises on the clock edge that consumes the triggering byte and lasts exactly 1 cycle.
- latitude through num_sats change on the same edge as data_valid.
- At most one of the three pulses is high in any cycle.
- Cycles with rx_valid low do not advance state, counters or the checksum.

## Structure
- The shared package nmea_pkg holds:
  - ASCII constants ('$', ',', '*', '.', 'N', 'S', 'E', 'W', 'G', 'A').
  - The state enum.
  - is_digit and hex_to_nibble functions.
- Sub-module nmea_dec_acc:
  - Parameters W and MAX_D.
  - Inputs clr, en, digit[3:0].
  - Outputs value[W-1:0] and digit count.
  - Instantiated twice, for latitude and longitude.
- num_sats and fix stay inline.

## Test plan
- "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47" back-to-back → data_valid 1 cycle; latitude=4807038, longitude=1131000, lat_south=0, lon_west=0, fix_quality=1, num_sats=8.
- Same sentence with "*48" → cksum_err pulse; outputs keep their previous values.
- "$GNGGA…,S,…,W,…" with a correct checksum → data_valid; lat_south=1, lon_west=1. Then "$GPRMC,…" → no pulses.
- GGA with fix field '0' and a correct checksum → no pulses; outputs unchanged. Then a 90-character line with no '*' → fmt_err at character 83.
- '$' injected mid-field, followed by a full valid sentence → exactly one data_valid and no errors. Separately, assert rst mid-sentence → all outputs 0, then the next valid sentence parses.
- rx_valid gaps of random length between bytes of sentence 1 → results identical to the back-to-back run.
